// File: rtl/led_pwm_pkg.sv
// Shared constants and types for the LED PWM fader slice.
// Gamma correction is selected at build time with LED_PWM_FADER_GAMMA_EN.
package led_pwm_pkg;

  localparam int LED_COUNT = 8;
  localparam int DUTY_W    = 8;

  typedef logic [DUTY_W-1:0] duty_t;

  localparam duty_t DUTY_MAX = 8'hFF;

endpackage

// File: rtl/led_pwm_fader_if.sv
// LED request/drive bundle between the PIO side (master) and the fader (slave).
interface led_pwm_fader_if;
  import led_pwm_pkg::*;

  logic [LED_COUNT-1:0] led_req;
  logic                 fade_bypass;
  logic [LED_COUNT-1:0] led_drive;
  logic                 busy;

  modport master (
    output led_req,
    output fade_bypass,
    input  led_drive,
    input  busy
  );

  modport slave (
    input  led_req,
    input  fade_bypass,
    output led_drive,
    output busy
  );

endinterface

// File: rtl/led_fade_channel.sv
// One LED channel: duty register with saturating ramp, optional gamma
// (LED_PWM_FADER_GAMMA_EN), PWM compare and registered drive bit.
module led_fade_channel
  import led_pwm_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  req,
  input  logic  bypass,
  input  logic  fade_tick,
  input  duty_t pwm_cnt,
  output logic  drive,
  output logic  at_target
);

  localparam duty_t STEP_D = duty_t'(STEP);

  duty_t      duty;
  duty_t      target;
  duty_t      duty_up;
  duty_t      duty_dn;
  duty_t      duty_nxt;
  duty_t      eff;
  logic [8:0] sum;

`ifdef LED_PWM_FADER_GAMMA_EN
  logic [15:0] prod;
`endif

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    target   = req ? DUTY_MAX : '0;
    sum      = {1'b0, duty} + {1'b0, STEP_D};
    duty_up  = sum[8] ? DUTY_MAX : sum[7:0];
    duty_dn  = (duty < STEP_D) ? '0 : duty - STEP_D;
    duty_nxt = duty;
    if (bypass)
      duty_nxt = target;
    else if (fade_tick)
      duty_nxt = req ? duty_up : duty_dn;
  end

`ifdef LED_PWM_FADER_GAMMA_EN
  // Squaring the duty spreads the perceived brightness evenly over the ramp.
  assign prod = duty * duty;
  assign eff  = prod[15:8];
`else
  assign eff  = duty;
`endif

  assign at_target = (duty == target);

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      duty  <= '0;
      drive <= 1'b0;
    end else begin
      duty  <= duty_nxt;
      drive <= (duty == DUTY_MAX) | (eff > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_pwm_fader.sv
// PWM fader for the 8 PIO LED outputs: shared prescaler, PWM counter and fade
// divider feeding eight channels. Optional gamma via LED_PWM_FADER_GAMMA_EN.
module led_pwm_fader
  import led_pwm_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int FADE_DIV = 64,
  parameter int STEP     = 4
) (
  input logic           clk,
  input logic           reset_n,
  led_pwm_fader_if.slave bus
);

  localparam logic [15:0] PRE_LAST  = 16'(PRESCALE - 1);
  localparam logic [15:0] FADE_LAST = 16'(FADE_DIV - 1);

  logic [15:0]          pre_cnt;
  logic [15:0]          fade_cnt;
  duty_t                pwm_cnt;
  logic                 pwm_tick;
  logic                 period_end;
  logic                 fade_tick;
  logic                 busy_q;
  logic [LED_COUNT-1:0] at_target;
  logic [LED_COUNT-1:0] drive_bits;

  assign pwm_tick   = (pre_cnt == PRE_LAST);
  assign period_end = pwm_tick && (pwm_cnt == DUTY_MAX);
  assign fade_tick  = period_end && (fade_cnt == FADE_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt  <= '0;
      pwm_cnt  <= '0;
      fade_cnt <= '0;
      busy_q   <= 1'b0;
    end else begin
      pre_cnt <= pwm_tick ? '0 : pre_cnt + 16'd1;
      if (pwm_tick)
        pwm_cnt <= pwm_cnt + 8'd1;
      if (period_end)
        fade_cnt <= fade_tick ? '0 : fade_cnt + 16'd1;
      busy_q <= ~&at_target;
    end
  end

  for (genvar i = 0; i < LED_COUNT; i++) begin : g_ch
    led_fade_channel #(
      .STEP (STEP)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (bus.led_req[i]),
      .bypass    (bus.fade_bypass),
      .fade_tick (fade_tick),
      .pwm_cnt   (pwm_cnt),
      .drive     (drive_bits[i]),
      .at_target (at_target[i])
    );
  end

  assign bus.led_drive = drive_bits;
  assign bus.busy      = busy_q;

endmodule

// File: doc/led_pwm_fader.md
# led_pwm_fader

Downstream consumer of the 8-bit LED PIO output register. It converts each static on/off request bit into a PWM-dimmed board LED drive that ramps smoothly between off and full-on. It sits between the PIO `out_port` and the FPGA LED pins, and runs entirely in the PIO's clock domain, so no synchronizer is needed.

## Interface
- `PRESCALE`, default 4: clk cycles per PWM counter step; legal range 1..65535.
- `FADE_DIV`, default 64: PWM periods per fade step; legal range 1..65535.
- `STEP`, default 4: duty increment/decrement per fade step; legal range 1..255.
- `clk`  in  1  clock; all state on the rising edge.
- `reset_n`  in  1  reset: asynchronous, active-low.
- `led_req`  in  8  per-LED request, taken directly from the PIO `out_port`; 1 = on.
- `fade_bypass`  in  1  1 = snap duty to target without ramping.
- `led_drive`  out  8  registered PWM drive to the LED pins.
- `busy`  out  1  registered; 1 while any channel's duty is not at its target.

## Operation
- Prescaler `pre_cnt`:
  - Counts 0..PRESCALE-1.
  - `pwm_tick` is asserted when `pre_cnt`==PRESCALE-1; `pre_cnt` then wraps to 0.
- PWM counter `pwm_cnt` (8 bit):
  - Increments on `pwm_tick`, wrapping 255->0.
  - `period_end` = `pwm_tick` && `pwm_cnt`==255.
- Fade divider `fade_cnt`:
  - Counts `period_end` events 0..FADE_DIV-1.
  - `fade_tick` = `period_end` && `fade_cnt`==FADE_DIV-1.
- Per channel i, 8-bit `duty[i]`, target T = `led_req[i]` ? 255 : 0:
  - `fade_bypass`=1: `duty` <= T on every clk. This takes priority over `fade_tick`.
  - Otherwise, on `fade_tick`:
    - If `led_req[i]`: `duty` <= min(255, `duty`+STEP), using a 9-bit intermediate with saturation.
    - If not `led_req[i]`: `duty` <= max(0, `duty`-STEP), saturating at 0.
  - Otherwise `duty` holds.
- A request change mid-ramp reverses direction at the next `fade_tick`, starting from the current `duty`. There is no restart from an endpoint.
- Effective duty E = `duty` (see Configuration).
- `led_drive[i]` <= (`duty[i]`==255) | (E > `pwm_cnt`):
  - `duty`=0 gives constant off.
  - `duty`=255 gives constant on.
- `busy` <= OR over i of (`duty[i]` != T_i).
- Channels are fully independent. All eight share one prescaler, PWM counter and fade divider.

## Timing
- Reset values: `pre_cnt`, `pwm_cnt`, `fade_cnt` = 0; all `duty` = 0; `led_drive` = 8'h00; `busy` = 0.
- `led_drive` latency: 1 clk after the `duty`/`pwm_cnt` values it is computed from.
- `busy` latency:
  - Asserts 1 clk after a `led_req` change creates a mismatch.
  - Deasserts 1 clk after the last channel reaches its target.
- Bypass path: `led_req` change -> `duty` updated next clk -> `led_drive` final one clk later (2 clk total).
- Full ramp 0->255 takes ceil(255/STEP) fade steps, each PRESCALE*256*FADE_DIV clk.
- Reset asserted mid-ramp clears all state immediately (asynchronous). After release the block resumes from `duty`=0.
- `led_req` change and `fade_tick` in the same clk: the step uses the new `led_req` value.

## Configuration
- `LED_PWM_FADER_GAMMA_EN` defined: E = (`duty`*`duty`)>>8, an 8-bit result of a 16-bit product. This gives a perceptually even fade. The `duty`==255 force-on is still applied.
- Not defined: E = `duty` (linear); no multiplier is synthesized.
- The macro does not affect ramp timing or `busy`.

## Structure
- Shared package `led_pwm_pkg`:
  - `LED_COUNT`=8, `DUTY_W`=8, `DUTY_MAX`=8'hFF.
  - typedef `duty_t` (logic [7:0]).
- Sub-module `led_fade_channel`, instantiated 8 times. It holds one `duty` register, the saturating step logic, optional gamma, the compare and the `led_drive` bit. It exports an at-target flag.
- The top holds the prescaler, `pwm_cnt`, `fade_cnt` and the `busy` OR-reduce.

## Test plan
1. Reset release, `led_req`=8'h00, params 1/1/255 -> `led_drive`=8'h00 and `busy`=0 for 1000 clk.
2. PRESCALE=1, FADE_DIV=1, STEP=64, `led_req`=8'h01 -> `duty[0]` reaches 64, 128, 192, 255 at successive `fade_tick`s, 256 clk apart. `busy` drops 1 clk after 255. `led_drive[0]` is then high constantly.
3. Linear build, `duty`=64 held, PRESCALE=1 -> `led_drive[0]` high for exactly 64 of every 256 clk.
4. Mid-ramp reversal at `duty`=128, STEP=64: `led_req[0]` 1->0 -> next `fade_tick` gives 64, then 0. `led_drive[0]` is constant low after that.
5. `fade_bypass`=1, `led_req` 8'h00->8'hA5 -> `led_drive`=8'hA5 2 clk later. `busy` pulses for 1 clk only.
6. `reset_n` low mid-ramp (`duty`=192) -> `led_drive`=8'h00 asynchronously. After release the ramp restarts from 0. With `LED_PWM_FADER_GAMMA_EN` defined, `duty`=128 gives E=64.
